// File: rtl/fb_pixel_fetch.sv
// Wishbone classic read master that streams the frame buffer into a show-ahead
// pixel FIFO and restarts at pixel (0,0) on every frame_start pulse.
module fb_pixel_fetch #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 256
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst,
  input  logic                          frame_start,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [3:0]                    wb_sel,
  output logic [31:0]                   wb_adr,
  output logic [2:0]                    wb_cti,
  output logic [1:0]                    wb_bte,
  input  logic                          wb_ack,
  input  logic [31:0]                   wb_dat_sm,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [23:0]                   pix_data,
  output logic                          pix_sof,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [1:0]                    fsm_state
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          FRAME     = HDISP * VDISP;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (FRAME - 1));
  localparam logic [AW:0] DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DRAIN = 2'd2} state_t;

  // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge;
  // a bus read completes when wb_cyc && wb_stb && wb_ack at a rising edge.

  state_t        state_q;
  logic          cyc_q;
  logic [31:0]   adr_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d, level_after_push;
  logic          underrun_q;
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [24:0]   head;
  logic          push, pop;
  logic [31:0]   adr_next;
  logic          unused_dat_hi;

  assign unused_dat_hi = ^wb_dat_sm[31:24];

  assign head      = mem_q[rd_ptr_q];
  assign pix_valid = (level_q != '0);
  assign pix_data  = head[23:0];
  assign pix_sof   = pix_valid & head[24];

  // Flush wins over any same-cycle push or pop.
  assign push = (state_q == S_REQ) && wb_ack && !frame_start;
  assign pop  = pix_valid && pix_ready && !frame_start;

  assign adr_next         = (adr_q == LAST_ADDR) ? BASE_ADDR : adr_q + 32'd4;
  assign level_after_push = level_q + (AW + 1)'(1) - (AW + 1)'(pop);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (push) mem_q[wr_ptr_q] <= {adr_q == BASE_ADDR, wb_dat_sm[23:0]};
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      adr_q      <= BASE_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (frame_start) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        underrun_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_d;
        if (pix_ready && !pix_valid) underrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            adr_q <= BASE_ADDR;
          end else if (level_q < DEPTH_L) begin
            state_q <= S_REQ;
            cyc_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (wb_ack) begin
            if (frame_start) begin
              state_q <= S_IDLE;
              cyc_q   <= 1'b0;
              adr_q   <= BASE_ADDR;
            end else begin
              adr_q <= adr_next;
              if (level_after_push >= DEPTH_L) begin
                state_q <= S_IDLE;
                cyc_q   <= 1'b0;
              end
            end
          end else if (frame_start) begin
            // Address stays put so the abandoned read remains a legal bus cycle.
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wb_ack) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= BASE_ADDR;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_adr     = adr_q;
  assign wb_cti     = 3'b000;
  assign wb_bte     = 2'b00;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Randomized bench for fb_pixel_fetch: a queue-based frame/FIFO model predicts
// bus, stream and flag outputs every cycle.
module tb_fb_pixel_fetch;
  localparam int          HD    = 8;
  localparam int          VD    = 4;
  localparam int          FRAME = HD * VD;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1, fs = 1'b0, ack = 1'b0, rdy = 1'b0;
  logic [31:0] dat = 32'h0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        pix_valid, pix_sof, underrun;
  logic [23:0] pix_data;
  logic [4:0]  fifo_level;
  logic [1:0]  fsm_state;

  fb_pixel_fetch #(.HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .frame_start(fs),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_ack(ack), .wb_dat_sm(dat),
    .pix_valid(pix_valid), .pix_ready(rdy), .pix_data(pix_data), .pix_sof(pix_sof),
    .fifo_level(fifo_level), .underrun(underrun), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixels in flight as a queue, fetch position as a frame index.
  logic [24:0] exp_q[$];
  int  m_idx  = 0;
  int  m_hold = 0;
  bit  m_busy = 0;
  bit  m_drop = 0;
  bit  m_under = 0;

  task automatic model_update();
    int sz;
    bit a;
    if (rst) begin
      exp_q.delete(); m_idx = 0; m_busy = 0; m_drop = 0; m_under = 0;
      return;
    end
    sz = exp_q.size();
    a  = m_busy && ack;
    if (fs) begin
      exp_q.delete();
      m_under = 0;
      if (m_busy) begin
        if (a) begin m_busy = 0; m_drop = 0; end
        else if (!m_drop) begin m_drop = 1; m_hold = m_idx; end
      end
      m_idx = 0;
    end else begin
      if (rdy && sz == 0) m_under = 1;
      if (rdy && sz > 0) void'(exp_q.pop_front());
      if (a) begin
        if (m_drop) begin
          m_drop = 0; m_busy = 0;
        end else begin
          exp_q.push_back({m_idx == 0, dat[23:0]});
          m_idx  = (m_idx + 1) % FRAME;
          m_busy = exp_q.size() < DEPTH;
        end
      end else if (!m_busy) begin
        m_busy = sz < DEPTH;
      end
    end
  endtask

  task automatic check_outputs();
    check("cyc", wb_cyc, m_busy);
    check("stb", wb_stb, m_busy);
    if (m_busy) check("adr", wb_adr, BASE + 32'(4 * (m_drop ? m_hold : m_idx)));
    check("valid", pix_valid, exp_q.size() > 0);
    check("level", fifo_level, exp_q.size());
    if (exp_q.size() > 0) begin
      check("data", pix_data, exp_q[0][23:0]);
      check("sof", pix_sof, exp_q[0][24]);
    end else begin
      check("sof_empty", pix_sof, 0);
    end
    check("underrun", underrun, m_under);
  endtask

  // Slave and driver
  int lat = -1, wcnt = 0, lat_min = 0, lat_max = 0;

  task automatic drive(input bit f, input bit r, input bit rd, input bit force_ack);
    fs = f; rst = r; rdy = rd; ack = 1'b0;
    if (r) begin
      lat = -1;
    end else if (wb_cyc && wb_stb) begin
      if (lat < 0) begin lat = $urandom_range(lat_max, lat_min); wcnt = 0; end
      if (force_ack || wcnt >= lat) begin
        ack = 1'b1; dat = $urandom; lat = -1;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic step(input bit f, input bit r, input bit rd, input bit force_ack);
    drive(f, r, rd, force_ack);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  // Returns at a negedge with wb_cyc high and no wait started yet.
  task automatic wait_new_req();
    int n = 0;
    while (!(wb_cyc && lat < 0) && n < 60) begin step(0, 0, 0, 0); n++; end
    check("wait_req_timeout", n < 60, 1);
  endtask

  initial begin
    @(negedge clk);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("rst_adr", wb_adr, BASE);
    check("rst_cyc", wb_cyc, 0);
    check("rst_level", fifo_level, 0);
    check("rst_under", underrun, 0);
    check("we", wb_we, 0);
    check("sel", wb_sel, 4'hF);
    check("cti", wb_cti, 0);
    check("bte", wb_bte, 0);

    // Fill with a zero-latency slave and no consumer.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0);
    check("full_level", fifo_level, DEPTH);
    check("full_idle", wb_cyc, 0);

    // Single pop refills one slot.
    step(0, 0, 1, 0);
    check("pop_one", fifo_level, DEPTH - 1);
    step(0, 0, 0, 0);
    check("refill_req", wb_cyc, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("refill_full", fifo_level, DEPTH);

    // Slow slave, always-ready consumer.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 150; i++) step(0, 0, 1, 0);
    check("slow_under", underrun, 1);

    // frame_start during a pending read with 2-cycle ack.
    lat_min = 2; lat_max = 2;
    wait_new_req();
    step(1, 0, 0, 0);
    check("drain_cyc", wb_cyc, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("drain_under", underrun, 0);

    // frame_start coinciding with ack and a ready consumer.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    wait_new_req();
    step(1, 0, 1, 1);
    check("fs_ack_level", fifo_level, 0);
    step(0, 0, 0, 0);
    check("fs_ack_adr", wb_adr, BASE);

    // Mid-operation reset.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check("mid_rst_cyc", wb_cyc, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_adr", wb_adr, BASE);
    check("mid_rst_sof", pix_sof, 0);

    // Randomized traffic, varying consumer rate and slave latency.
    for (int blk = 0; blk < 12; blk++) begin
      int p_rdy;
      p_rdy   = $urandom_range(100, 10);
      lat_min = 0;
      lat_max = $urandom_range(4, 0);
      for (int i = 0; i < 300; i++)
        step($urandom_range(99, 0) < 2, $urandom_range(999, 0) < 3,
             $urandom_range(99, 0) < p_rdy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
